// File: rtl/iter_mul_unit_if.sv
// Request/response bundle between the CPU write-back stage and the iterative multiplier.
interface iter_mul_unit_if #(
  parameter int WIDTH = 32
);
  logic                 mul_start;
  logic                 mul_signed;
  logic [WIDTH-1:0]     mul_src1;
  logic [WIDTH-1:0]     mul_src2;
  logic                 mul_busy;
  logic                 mul_end;
  logic [2*WIDTH-1:0]   mul_product;

  modport master (
    output mul_start, mul_signed, mul_src1, mul_src2,
    input  mul_busy, mul_end, mul_product
  );

  modport slave (
    input  mul_start, mul_signed, mul_src1, mul_src2,
    output mul_busy, mul_end, mul_product
  );
endinterface

// File: rtl/iter_mul_unit.sv
// Iterative shift-add multiplier (IDLE/BUSY/DONE), radix-2 by default.
// Define MUL_RADIX4_EN to retire two multiplier bits per BUSY cycle.
module iter_mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  iter_mul_unit_if.slave bus
);

`ifdef MUL_RADIX4_EN
  localparam int ITERS = WIDTH / 2;
`else
  localparam int ITERS = WIDTH;
`endif
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 neg_q;
  logic                 busy_q;
  logic                 end_q;
  logic [2*WIDTH-1:0]   product_q;

  logic [2*WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   mcand_d;
  logic [WIDTH-1:0]     mplier_d;
  logic [2*WIDTH-1:0]   mcand_ext;

  // Most-negative input maps onto 2^(WIDTH-1), which fits the unsigned magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign mcand_ext = {{WIDTH{1'b0}}, mag(bus.mul_src1, bus.mul_signed)};

`ifdef MUL_RADIX4_EN
  logic [2*WIDTH-1:0]   mcand3_q;
  logic [2*WIDTH-1:0]   mcand3_d;

  always_comb begin
    addend = '0;
    case (mplier_q[1:0])
      2'd1:    addend = mcand_q;
      2'd2:    addend = mcand_q << 1;
      2'd3:    addend = mcand3_q;
      default: addend = '0;
    endcase
    acc_d    = acc_q + addend;
    mcand_d  = mcand_q << 2;
    mcand3_d = mcand3_q << 2;
    mplier_d = mplier_q >> 2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand3_q <= '0;
    end else if (state_q == IDLE && bus.mul_start) begin
      mcand3_q <= mcand_ext + (mcand_ext << 1);
    end else if (state_q == BUSY) begin
      mcand3_q <= mcand3_d;
    end
  end
`else
  always_comb begin
    addend   = mplier_q[0] ? mcand_q : '0;
    acc_d    = acc_q + addend;
    mcand_d  = mcand_q << 1;
    mplier_d = mplier_q >> 1;
  end
`endif

  // Outputs are registered so the DONE cycle presents a stable product and pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      end_q     <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.mul_start) begin
            state_q  <= BUSY;
            busy_q   <= 1'b1;
            mcand_q  <= mcand_ext;
            mplier_q <= mag(bus.mul_src2, bus.mul_signed);
            neg_q    <= bus.mul_signed & (bus.mul_src1[WIDTH-1] ^ bus.mul_src2[WIDTH-1]);
            acc_q    <= '0;
            cnt_q    <= CNT_W'(ITERS);
          end
        end
        BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q   <= DONE;
            end_q     <= 1'b1;
            product_q <= apply_sign(acc_d, neg_q);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          end_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          end_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mul_busy    = busy_q;
  assign bus.mul_end     = end_q;
  assign bus.mul_product = product_q;

endmodule
